// File: rtl/dispense_motor_ctrl.sv
// dispense_motor_ctrl
//   Controls a dispenser built from a DC agitator motor and a stepper feed motor.
//   A dispense request spins the DC motor up, then issues a size-dependent number
//   of stepper pulses, then raises handshake until the request is withdrawn.
//   A manual test mode drives either motor directly for bring-up.
//
// Ports
//   clk_i          system clock, all state on the rising edge
//   reset_i        asynchronous active-high reset
//   disp_i         dispense request (level)
//   size_i         dispense amount: 00 small, 01 medium, 10 large, 11 small
//   test_mode_i    manual test select, 000 = none
//   handshake_o    dispense complete
//   busy_o         high while a dispense is in progress (spin-up, stepping, done)
//   stepper_step_o stepper pulse train
//   stepper_dir_o  stepper direction, 0 clockwise / 1 counterclockwise
//   dc_pwm_o       DC motor PWM enable
//   dc_in1_o       DC direction input 1 (0/1 clockwise, 1/0 counterclockwise with in2)
//   dc_in2_o       DC direction input 2
//
// All outputs come straight from flops; their next values are decoded from the
// next-state signals so they change on the same edge as the state.

module dispense_motor_ctrl #(
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned STEP_HALF_SLOW = 3125,
    parameter int unsigned STEP_HALF_FAST = 2000,
    parameter int unsigned SPINUP_CYC     = 50000,
    parameter int unsigned SMALL_STEPS    = 100,
    parameter int unsigned MED_STEPS      = 200,
    parameter int unsigned LARGE_STEPS    = 300,
    parameter int unsigned DUTY_SLOW      = 64,
    parameter int unsigned DUTY_MOD       = 128,
    parameter int unsigned DUTY_FAST      = 192
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       disp_i,
    input  logic [1:0] size_i,
    input  logic [2:0] test_mode_i,
    output logic       handshake_o,
    output logic       busy_o,
    output logic       stepper_step_o,
    output logic       stepper_dir_o,
    output logic       dc_pwm_o,
    output logic       dc_in1_o,
    output logic       dc_in2_o
);

    localparam int unsigned HalfMax  = (STEP_HALF_SLOW > STEP_HALF_FAST) ?
                                       STEP_HALF_SLOW : STEP_HALF_FAST;
    localparam int unsigned StepsSm  = (SMALL_STEPS > MED_STEPS) ? SMALL_STEPS : MED_STEPS;
    localparam int unsigned StepsMax = (StepsSm > LARGE_STEPS) ? StepsSm : LARGE_STEPS;

    localparam int unsigned DivW  = $clog2(HalfMax + 1);
    localparam int unsigned SpinW = $clog2(SPINUP_CYC + 1);
    localparam int unsigned StepW = $clog2(StepsMax + 1);

    localparam logic [DivW-1:0]     HalfSlowLast = DivW'(STEP_HALF_SLOW - 1);
    localparam logic [DivW-1:0]     HalfFastLast = DivW'(STEP_HALF_FAST - 1);
    localparam logic [SpinW-1:0]    SpinLast     = SpinW'(SPINUP_CYC - 1);
    localparam logic [StepW-1:0]    SmallN       = StepW'(SMALL_STEPS);
    localparam logic [StepW-1:0]    MedN         = StepW'(MED_STEPS);
    localparam logic [StepW-1:0]    LargeN       = StepW'(LARGE_STEPS);
    localparam logic [PWM_BITS-1:0] DutySlowC    = PWM_BITS'(DUTY_SLOW);
    localparam logic [PWM_BITS-1:0] DutyModC     = PWM_BITS'(DUTY_MOD);
    localparam logic [PWM_BITS-1:0] DutyFastC    = PWM_BITS'(DUTY_FAST);

    localparam logic [2:0] TmNone      = 3'b000;
    localparam logic [2:0] TmStepSlCw  = 3'b001;
    localparam logic [2:0] TmStepSlCcw = 3'b010;
    localparam logic [2:0] TmStepFsCw  = 3'b011;
    localparam logic [2:0] TmDcSlCw    = 3'b100;
    localparam logic [2:0] TmDcSlCcw   = 3'b101;
    localparam logic [2:0] TmDcFsCw    = 3'b110;

    typedef enum logic [2:0] {
        StIdle,
        StSpinup,
        StStep,
        StDone,
        StTest
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          size_q, size_d;
    logic [2:0]          test_q, test_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [SpinW-1:0]    spin_cnt_q, spin_cnt_d;
    logic [DivW-1:0]     div_cnt_q, div_cnt_d;
    logic [StepW-1:0]    step_cnt_q, step_cnt_d;
    logic                step_q, step_d;
    logic                busy_q, busy_d;
    logic                handshake_q, handshake_d;
    logic                dir_q, dir_d;
    logic                pwm_q, pwm_d;
    logic                in1_q, in1_d;
    logic                in2_q, in2_d;

    logic [StepW-1:0]    target_n;
    logic [DivW-1:0]     test_half_last;
    logic                test_stepping;
    logic                pwm_en;
    logic [PWM_BITS-1:0] duty;

    // Next-state logic for the FSM and all counters.
    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        test_d     = test_q;
        spin_cnt_d = spin_cnt_q;
        div_cnt_d  = div_cnt_q;
        step_cnt_d = step_cnt_q;
        step_d     = step_q;
        pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);

        case (size_q)
            2'b01:   target_n = MedN;
            2'b10:   target_n = LargeN;
            default: target_n = SmallN;
        endcase

        test_stepping  = (test_q == TmStepSlCw) || (test_q == TmStepSlCcw) ||
                         (test_q == TmStepFsCw);
        test_half_last = (test_q == TmStepFsCw) ? HalfFastLast : HalfSlowLast;

        unique case (state_q)
            StIdle: begin
                spin_cnt_d = '0;
                div_cnt_d  = '0;
                step_cnt_d = '0;
                step_d     = 1'b0;
                // Test mode wins over a simultaneous dispense request.
                if (test_mode_i != TmNone) begin
                    state_d = StTest;
                    test_d  = test_mode_i;
                end else if (disp_i) begin
                    state_d = StSpinup;
                    size_d  = size_i;
                end
            end
            StSpinup: begin
                if (spin_cnt_q == SpinLast) begin
                    state_d    = StStep;
                    spin_cnt_d = '0;
                    div_cnt_d  = '0;
                    step_cnt_d = '0;
                    step_d     = 1'b0;
                end else begin
                    spin_cnt_d = spin_cnt_q + SpinW'(1);
                end
            end
            StStep: begin
                if (div_cnt_q == HalfSlowLast) begin
                    div_cnt_d = '0;
                    if (!step_q) begin
                        step_d     = 1'b1;
                        step_cnt_d = step_cnt_q + StepW'(1);
                    end else begin
                        // End of a high half-period: finish after the last pulse.
                        step_d = 1'b0;
                        if (step_cnt_q == target_n) begin
                            state_d = StDone;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DivW'(1);
                end
            end
            StDone: begin
                step_d = 1'b0;
                if (!disp_i) begin
                    state_d = StIdle;
                end
            end
            StTest: begin
                if (test_mode_i == TmNone) begin
                    state_d   = StIdle;
                    test_d    = TmNone;
                    div_cnt_d = '0;
                    step_d    = 1'b0;
                end else if (test_mode_i != test_q) begin
                    // Re-target: restart the divider from a low step output.
                    test_d    = test_mode_i;
                    div_cnt_d = '0;
                    step_d    = 1'b0;
                end else if (test_stepping) begin
                    if (div_cnt_q == test_half_last) begin
                        div_cnt_d = '0;
                        step_d    = ~step_q;
                    end else begin
                        div_cnt_d = div_cnt_q + DivW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from next state so every output is a flop.
    always_comb begin
        busy_d      = (state_d == StSpinup) || (state_d == StStep) || (state_d == StDone);
        handshake_d = (state_d == StDone);
        dir_d       = 1'b0;
        in1_d       = 1'b0;
        in2_d       = 1'b1;
        pwm_en      = 1'b0;
        duty        = DutyModC;

        case (state_d)
            StSpinup, StStep: begin
                pwm_en = 1'b1;
                duty   = DutyModC;
            end
            StTest: begin
                case (test_d)
                    TmStepSlCcw: dir_d = 1'b1;
                    TmDcSlCw: begin
                        pwm_en = 1'b1;
                        duty   = DutySlowC;
                    end
                    TmDcSlCcw: begin
                        pwm_en = 1'b1;
                        duty   = DutySlowC;
                        in1_d  = 1'b1;
                        in2_d  = 1'b0;
                    end
                    TmDcFsCw: begin
                        pwm_en = 1'b1;
                        duty   = DutyFastC;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase

        // Compare against the counter value that will be live alongside this flop.
        pwm_d = pwm_en && (pwm_cnt_d < duty);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            size_q      <= 2'b00;
            test_q      <= TmNone;
            pwm_cnt_q   <= '0;
            spin_cnt_q  <= '0;
            div_cnt_q   <= '0;
            step_cnt_q  <= '0;
            step_q      <= 1'b0;
            busy_q      <= 1'b0;
            handshake_q <= 1'b0;
            dir_q       <= 1'b0;
            pwm_q       <= 1'b0;
            in1_q       <= 1'b0;
            in2_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            test_q      <= test_d;
            pwm_cnt_q   <= pwm_cnt_d;
            spin_cnt_q  <= spin_cnt_d;
            div_cnt_q   <= div_cnt_d;
            step_cnt_q  <= step_cnt_d;
            step_q      <= step_d;
            busy_q      <= busy_d;
            handshake_q <= handshake_d;
            dir_q       <= dir_d;
            pwm_q       <= pwm_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
        end
    end

    assign handshake_o    = handshake_q;
    assign busy_o         = busy_q;
    assign stepper_step_o = step_q;
    assign stepper_dir_o  = dir_q;
    assign dc_pwm_o       = pwm_q;
    assign dc_in1_o       = in1_q;
    assign dc_in2_o       = in2_q;

endmodule

// File: tb/tb_dispense_motor_ctrl.sv
// tb_dispense_motor_ctrl
//   Scoreboard bench for dispense_motor_ctrl with small parameters
//   (half periods 4/2, spin-up 10, steps 3/6/9, 4-bit PWM, duties 4/8/12).
//   Stimulus pushes expected dispense results and test-mode observations into
//   queues; two monitors on the falling clock edge pop and compare.

module tb_dispense_motor_ctrl;

    localparam int SpinCyc  = 10;
    localparam int HalfSlow = 4;
    localparam int WinLen   = 32;

    logic       clk;
    logic       reset;
    logic       disp;
    logic [1:0] size;
    logic [2:0] test_mode;
    logic       handshake;
    logic       busy;
    logic       stepper_step;
    logic       stepper_dir;
    logic       dc_pwm;
    logic       dc_in1;
    logic       dc_in2;

    int checks = 0;
    int passes = 0;

    dispense_motor_ctrl #(
        .PWM_BITS      (4),
        .STEP_HALF_SLOW(4),
        .STEP_HALF_FAST(2),
        .SPINUP_CYC    (10),
        .SMALL_STEPS   (3),
        .MED_STEPS     (6),
        .LARGE_STEPS   (9),
        .DUTY_SLOW     (4),
        .DUTY_MOD      (8),
        .DUTY_FAST     (12)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .disp_i        (disp),
        .size_i        (size),
        .test_mode_i   (test_mode),
        .handshake_o   (handshake),
        .busy_o        (busy),
        .stepper_step_o(stepper_step),
        .stepper_dir_o (stepper_dir),
        .dc_pwm_o      (dc_pwm),
        .dc_in1_o      (dc_in1),
        .dc_in2_o      (dc_in2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Free-running 4-bit PWM counter reference.
    int pcnt;
    always @(posedge clk or posedge reset) begin
        if (reset) pcnt <= 0;
        else       pcnt <= (pcnt + 1) % 16;
    end

    // ---------------- dispense scoreboard ----------------
    typedef struct {
        int pulses;
        int cycles;
        int hs_len;
    } disp_exp_t;

    disp_exp_t dq[$];
    disp_exp_t a_e;
    bit   a_in, a_in_hs;
    int   a_cyc, a_pulses, a_hi, a_err, a_hs, a_done_err, a_exp_hs;
    logic a_prev;

    always @(negedge clk) begin
        if (reset) begin
            a_in    = 1'b0;
            a_in_hs = 1'b0;
        end else begin
            if (!a_in && busy) begin
                a_in       = 1'b1;
                a_cyc      = 0;
                a_pulses   = 0;
                a_hi       = 0;
                a_err      = 0;
                a_done_err = 0;
            end
            if (a_in && !a_in_hs && !handshake) begin
                a_cyc++;
                if (stepper_step && !a_prev) a_pulses++;
                if (stepper_step) a_hi++;
                if (!busy || (dc_pwm != (pcnt < 8)) || stepper_dir || dc_in1 || !dc_in2)
                    a_err++;
            end else if (a_in && handshake) begin
                if (!a_in_hs) begin
                    a_in_hs = 1'b1;
                    a_hs    = 0;
                    check("handshake_expected", int'(dq.size() > 0), 1);
                    if (dq.size() > 0) begin
                        a_e = dq.pop_front();
                        check("pulse_count", a_pulses, a_e.pulses);
                        check("busy_cycles_before_done", a_cyc, a_e.cycles);
                        check("step_high_cycles", a_hi, HalfSlow * a_e.pulses);
                        check("run_signal_errors", a_err, 0);
                        a_exp_hs = a_e.hs_len;
                    end else begin
                        a_exp_hs = -1;
                    end
                end
                a_hs++;
                if (dc_pwm || stepper_step || !busy) a_done_err++;
            end else if (a_in_hs && !handshake) begin
                check("handshake_length", a_hs, a_exp_hs);
                check("done_signal_errors", a_done_err, 0);
                check("busy_after_done", busy, 0);
                a_in    = 1'b0;
                a_in_hs = 1'b0;
            end
        end
        a_prev = stepper_step;
    end

    // ---------------- test-mode observation scoreboard ----------------
    typedef struct {
        int rises;
        int step_hi;
        int pwm_hi;
        int dir;
        int in1;
        int in2;
    } meas_t;

    meas_t mq[$];
    meas_t b_m;
    bit    b_active;
    int    b_n, b_rises, b_hi, b_pwm, b_lvl_err, b_busy;
    logic  b_prev;

    always @(negedge clk) begin
        if (!b_active && mq.size() > 0 && !reset) begin
            b_active  = 1'b1;
            b_m       = mq[0];
            b_n       = 0;
            b_rises   = 0;
            b_hi      = 0;
            b_pwm     = 0;
            b_lvl_err = 0;
            b_busy    = 0;
        end
        if (b_active) begin
            b_n++;
            if (stepper_step && !b_prev) b_rises++;
            if (stepper_step) b_hi++;
            if (dc_pwm) b_pwm++;
            if (stepper_dir != b_m.dir[0] || dc_in1 != b_m.in1[0] || dc_in2 != b_m.in2[0])
                b_lvl_err++;
            if (busy || handshake) b_busy++;
            if (b_n == WinLen) begin
                void'(mq.pop_front());
                check("test_step_rises", b_rises, b_m.rises);
                check("test_step_high", b_hi, b_m.step_hi);
                check("test_pwm_high", b_pwm, b_m.pwm_hi);
                check("test_level_errors", b_lvl_err, 0);
                check("test_busy_or_handshake", b_busy, 0);
                b_active = 1'b0;
            end
        end
        b_prev = stepper_step;
    end

    // ---------------- stimulus ----------------
    task automatic wait_handshake();
        int i = 0;
        while (!handshake && i < 400) begin
            @(posedge clk); #1;
            i++;
        end
        check("handshake_seen", handshake, 1);
    endtask

    task automatic dispense(input logic [1:0] sz, input int n, input int hold,
                            input bit drop_early, input bit chg, input logic [1:0] sz_new);
        disp_exp_t e;
        e.pulses = n;
        e.cycles = SpinCyc + 2 * HalfSlow * n;
        e.hs_len = drop_early ? 1 : hold + 1;
        dq.push_back(e);
        check("busy_before_request", busy, 0);
        size = sz;
        disp = 1'b1;
        @(posedge clk); #1;
        check("busy_next_cycle", busy, 1);
        if (drop_early) begin
            repeat (3) @(posedge clk);
            #1 disp = 1'b0;
        end else if (chg) begin
            repeat (12) @(posedge clk);
            #1 size = sz_new;
        end
        wait_handshake();
        if (!drop_early) begin
            repeat (hold) @(posedge clk);
            #1 disp = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic push_meas(input int rises, input int step_hi, input int pwm_hi,
                             input int dir, input int in1, input int in2);
        meas_t m;
        m.rises   = rises;
        m.step_hi = step_hi;
        m.pwm_hi  = pwm_hi;
        m.dir     = dir;
        m.in1     = in1;
        m.in2     = in2;
        mq.push_back(m);
    endtask

    task automatic wait_meas();
        int i = 0;
        while ((mq.size() > 0 || b_active) && i < 100) begin
            @(posedge clk); #1;
            i++;
        end
        check("test_window_done", mq.size() + int'(b_active), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_handshake"}, handshake, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_step"}, stepper_step, 0);
        check({tag, "_dir"}, stepper_dir, 0);
        check({tag, "_dc_pwm"}, dc_pwm, 0);
        check({tag, "_dc_in1"}, dc_in1, 0);
        check({tag, "_dc_in2"}, dc_in2, 1);
    endtask

    initial begin
        int   rises;
        int   i;
        logic prev;

        reset     = 1'b1;
        disp      = 1'b0;
        size      = 2'b00;
        test_mode = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Small dispense, request held for two cycles after completion.
        dispense(2'b00, 3, 2, 1'b0, 1'b0, 2'b00);
        // Size 11 dispenses the small amount.
        dispense(2'b11, 3, 0, 1'b0, 1'b0, 2'b00);
        // Large dispense; size changed mid-stepping must not alter the count.
        dispense(2'b10, 9, 1, 1'b0, 1'b1, 2'b00);
        // Medium dispense with request dropped during spin-up.
        dispense(2'b01, 6, 0, 1'b1, 1'b0, 2'b00);

        // Stepper slow counterclockwise: 8-cycle pulses.
        test_mode = 3'b010;
        @(posedge clk); #1;
        check("tm010_dir", stepper_dir, 1);
        check("tm010_busy", busy, 0);
        push_meas(WinLen / 8, WinLen / 2, 0, 1, 0, 1);
        wait_meas();

        // Stepper fast clockwise: 4-cycle pulses, step restarts low.
        test_mode = 3'b011;
        @(posedge clk); #1;
        check("tm011_step_low", stepper_step, 0);
        check("tm011_dir", stepper_dir, 0);
        push_meas(WinLen / 4, WinLen / 2, 0, 0, 0, 1);
        wait_meas();

        // DC slow counterclockwise: 4 of 16 cycles high, disp pulses ignored.
        test_mode = 3'b101;
        @(posedge clk); #1;
        push_meas(0, 0, 8, 0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            disp = ~disp;
            repeat (2) @(posedge clk);
            #1;
        end
        disp = 1'b0;
        wait_meas();

        // DC fast clockwise: 12 of 16 cycles high.
        test_mode = 3'b110;
        @(posedge clk); #1;
        push_meas(0, 0, 24, 0, 0, 1);
        wait_meas();

        // Leaving test mode returns every output to its reset value.
        test_mode = 3'b000;
        @(posedge clk); #1;
        check_reset_outputs("test_exit");
        repeat (2) @(posedge clk);
        #1;

        // Reset during stepping after the second pulse.
        size  = 2'b00;
        disp  = 1'b1;
        rises = 0;
        i     = 0;
        prev  = 1'b0;
        while (rises < 2 && i < 200) begin
            @(posedge clk); #1;
            if (stepper_step && !prev) rises++;
            prev = stepper_step;
            i++;
        end
        check("two_pulses_before_reset", rises, 2);
        @(posedge clk); #1;
        reset = 1'b1;
        disp  = 1'b0;
        #2;
        check_reset_outputs("reset_mid_step");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("no_restart_after_reset", busy, 0);
        dispense(2'b00, 3, 1, 1'b0, 1'b0, 2'b00);

        check("expected_queue_drained", dq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/dispense_motor_ctrl.md
DISPENSE_MOTOR_CTRL -- requirements
Module: dispense_motor_ctrl

Interface
REQ-001 Parameter PWM_BITS, 8, DC PWM counter/duty width.
REQ-002 Parameter STEP_HALF_SLOW, 3125, clk cycles per stepper_step half-period, slow/dispense rate.
REQ-003 Parameter STEP_HALF_FAST, 2000, clk cycles per half-period, fast test rate.
REQ-004 Parameter SPINUP_CYC, 50000, DC run cycles before stepping starts.
REQ-005 Parameters SMALL_STEPS/MED_STEPS/LARGE_STEPS, 100/200/300, step counts per size.
REQ-006 Parameters DUTY_SLOW/DUTY_MOD/DUTY_FAST, 64/128/192, PWM duty codes.
REQ-007 Single clock; reset asynchronous, active-high.
REQ-008 clk  in  1  system clock, all state on rising edge.
REQ-009 reset  in  1  async active-high reset.
REQ-010 disp  in  1  dispense request, level.
REQ-011 size  in  2  dispense amount: 00 small, 01 medium, 10 large, 11 small.
REQ-012 test_mode  in  3  manual test select, 000 = none.
REQ-013 handshake  out  1  dispense complete.
REQ-014 busy  out  1  high in SPINUP, STEP, DONE.
REQ-015 stepper_step  out  1  step pulse train.
REQ-016 stepper_dir  out  1  0 clockwise, 1 counterclockwise.
REQ-017 dc_pwm  out  1  DC motor PWM enable.
REQ-018 dc_in1, dc_in2  out  1 each  DC direction; 0/1 clockwise, 1/0 counterclockwise.

Function
REQ-019 States IDLE, SPINUP, STEP, DONE, TEST; one-hot or binary at implementer's choice.
REQ-020 IDLE: disp=1 and test_mode=000 -> SPINUP next cycle; size latched that edge.
REQ-021 IDLE: test_mode!=000 -> TEST next cycle; test_mode takes priority over disp when both present.
REQ-022 SPINUP: dc_pwm driven at DUTY_MOD, clockwise; exactly SPINUP_CYC cycles, then STEP.
REQ-023 STEP: stepper_step starts low, toggles every STEP_HALF_SLOW cycles; DC stays at DUTY_MOD.
REQ-024 STEP: step counter increments on each stepper_step rising edge; after the Nth rising edge and its high half-period, stepper_step low -> DONE; STEP lasts exactly 2*N*STEP_HALF_SLOW cycles.
REQ-025 DONE: dc_pwm=0, stepper_step=0, handshake=1; held until disp=0, then IDLE next cycle, handshake=0.
REQ-026 disp falling during SPINUP/STEP ignored; dispense completes; DONE then exits one cycle later.
REQ-027 size and test_mode changes while busy ignored.
REQ-028 TEST mapping: 001 step slow CW; 010 step slow CCW; 011 step fast CW; 100 DC DUTY_SLOW CW; 101 DC DUTY_SLOW CCW; 110 DC DUTY_FAST CW; 111 all off. Step counter not used; stepping continuous.
REQ-029 TEST: test_mode change re-targets outputs next cycle, step divider restarts, stepper_step low; test_mode=000 -> IDLE next cycle with all outputs at reset values.
REQ-030 disp ignored in TEST; handshake=0 throughout TEST.
REQ-031 PWM: free-running PWM_BITS counter, wraps 2^PWM_BITS-1 -> 0; dc_pwm = enable AND (cnt < duty); duty 0 never high, duty 2^PWM_BITS-1 low one cycle per period.
REQ-032 Dividers and step counter sized by $clog2 of their maxima; no overflow for any legal parameter set.
REQ-033 All outputs registered; no combinational path input -> output.

Reset
REQ-034 Reset asserted: state IDLE, handshake=0, busy=0, stepper_step=0, stepper_dir=0, dc_pwm=0, dc_in1=0, dc_in2=1, all counters 0, asynchronously.
REQ-035 Reset mid-dispense aborts immediately; no handshake; after release, new dispense requires disp sampled high in IDLE.

Verification (bench params: STEP_HALF_SLOW=4, STEP_HALF_FAST=2, SPINUP_CYC=10, steps 3/6/9, PWM_BITS=4, duties 4/8/12)
REQ-036 size=00, disp high held -> busy next cycle, dc_pwm 8/16 duty 10 cycles, then 3 stepper pulses of 8-cycle period (24 cycles), handshake=1; disp low -> handshake=0 next cycle.
REQ-037 size=11 -> exactly 3 pulses; size=10 -> 9 pulses; size changed during STEP -> count unchanged.
REQ-038 test_mode=010 -> stepper_dir=1, continuous 8-cycle pulses; switch to 011 -> 4-cycle pulses, dir=0; 000 -> IDLE, outputs reset values.
REQ-039 test_mode=101 -> dc_in1=1, dc_in2=0, dc_pwm high 4 of every 16 cycles; disp pulses ignored.
REQ-040 reset asserted during STEP after pulse 2 -> all outputs reset values same cycle; no handshake; fresh dispense after release yields full 3 pulses.
REQ-041 disp dropped during SPINUP -> dispense completes, handshake high exactly one cycle.
